// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator: pixel-rate enable, counters,
// registered syncs, video-active flag and frame-start pulse.
module vga_sync_gen #(
  parameter int DIV = 4,
  parameter int HD  = 640,
  parameter int HF  = 16,
  parameter int HR  = 96,
  parameter int HB  = 48,
  parameter int VD  = 480,
  parameter int VF  = 10,
  parameter int VR  = 2,
  parameter int VB  = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pix_tick,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start
);

  localparam int HT = HD + HF + HR + HB;
  localparam int VT = VD + VF + VR + VB;
  localparam int DW = $clog2(DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  localparam logic [9:0] X_LAST = 10'(HT - 1);
  localparam logic [9:0] Y_LAST = 10'(VT - 1);
  localparam logic [9:0] X_VIS  = 10'(HD);
  localparam logic [9:0] Y_VIS  = 10'(VD);
  localparam logic [9:0] HS_BEG = 10'(HD + HF);
  localparam logic [9:0] HS_END = 10'(HD + HF + HR - 1);
  localparam logic [9:0] VS_BEG = 10'(VD + VF);
  localparam logic [9:0] VS_END = 10'(VD + VF + VR - 1);

  logic [DW-1:0] div_q, div_d;
  logic [9:0]    x_q, x_d;
  logic [9:0]    y_q, y_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          von_q, von_d;
  logic          fstart_q, fstart_d;

  logic tick;
  logic x_end;
  logic y_end;

  function automatic logic in_rng(
    input logic [9:0] v,
    input logic [9:0] lo,
    input logic [9:0] hi
  );
    return (v >= lo) && (v <= hi);
  endfunction

  assign tick  = (div_q == DIV_LAST);
  assign x_end = (x_q == X_LAST);
  assign y_end = (y_q == Y_LAST);

  // Clock divider: free-running 0..DIV-1, pixel enable on last count.
  always_comb begin
    div_d = div_q + 1'b1;
    if (tick) div_d = '0;
  end

  // Raster counters: x on every pixel enable, y at end of each line.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    unique case (1'b1)
      !tick: begin
      end
      tick && !x_end: begin
        x_d = x_q + 10'd1;
      end
      tick && x_end && !y_end: begin
        x_d = '0;
        y_d = y_q + 10'd1;
      end
      default: begin
        x_d = '0;
        y_d = '0;
      end
    endcase
  end

  // Decode from next-state counters so outputs align with pix_x/pix_y.
  always_comb begin
    hsync_d  = !in_rng(x_d, HS_BEG, HS_END);
    vsync_d  = !in_rng(y_d, VS_BEG, VS_END);
    von_d    = (x_d < X_VIS) && (y_d < Y_VIS);
    fstart_d = tick && x_end && y_end;
  end

  // State registers; reset parks everything at pixel (0,0).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      von_q    <= 1'b1;
      fstart_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      x_q      <= x_d;
      y_q      <= y_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      von_q    <= von_d;
      fstart_q <= fstart_d;
    end
  end

  assign pix_tick    = tick;
  assign pix_x       = x_q;
  assign pix_y       = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = von_q;
  assign frame_start = fstart_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default-timing instance (DIV=4) plus a DIV=2
// instance with a 10-line frame so vertical/frame events are reachable.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;

  logic       tick_a, hs_a, vs_a, vo_a, fs_a;
  logic [9:0] x_a, y_a;
  logic       tick_b, hs_b, vs_b, vo_b, fs_b;
  logic [9:0] x_b, y_b;

  vga_sync_gen dut_a (
    .clk(clk), .reset(rst_a), .pix_tick(tick_a),
    .pix_x(x_a), .pix_y(y_a), .hsync(hs_a), .vsync(vs_a),
    .video_on(vo_a), .frame_start(fs_a)
  );

  vga_sync_gen #(
    .DIV(2), .VD(4), .VF(2), .VR(2), .VB(2)
  ) dut_b (
    .clk(clk), .reset(rst_b), .pix_tick(tick_b),
    .pix_x(x_b), .pix_y(y_b), .hsync(hs_b), .vsync(vs_b),
    .video_on(vo_b), .frame_start(fs_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic goto(input int c);
    if (c > cyc) adv(c - cyc);
  endtask

  int lo, fall, rise, fx, rx, fsn;
  int vo_late, vo_l3, fs_first;

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    adv(10);
    chk("rst_x_a", x_a, 0);
    chk("rst_y_a", y_a, 0);
    chk("rst_hs_a", hs_a, 1);
    chk("rst_vs_a", vs_a, 1);
    chk("rst_vo_a", vo_a, 1);
    chk("rst_fs_a", fs_a, 0);
    chk("rst_tick_a", tick_a, 0);
    chk("rst_tick_b", tick_b, 0);
    chk("rst_x_b", x_b, 0);

    rst_a = 1'b1;
    rst_b = 1'b1;
    cyc = 0;
    for (int i = 0; i < 8; i++) begin
      chk("tick_a_seq", tick_a, 32'(i % 4 == 3));
      chk("tick_b_seq", tick_b, 32'(i % 2 == 1));
      adv(1);
    end
    chk("x_a_c8", x_a, 2);
    chk("x_b_c8", x_b, 4);

    goto(2559);
    chk("x_a_639", x_a, 639);
    chk("vo_a_639", vo_a, 1);
    chk("hs_a_639", hs_a, 1);
    adv(1);
    chk("x_a_640", x_a, 640);
    chk("vo_a_640", vo_a, 0);

    lo = 0; fall = -1; rise = -1; fx = 0; rx = 0; fsn = 0;
    for (int i = 0; i < 639; i++) begin
      if (!hs_a) begin
        lo++;
        if (fall < 0) begin fall = cyc; fx = int'(x_a); end
      end else if (fall >= 0 && rise < 0) begin
        rise = cyc; rx = int'(x_a);
      end
      fsn += int'(fs_a);
      adv(1);
    end
    chk("hs_a_fall_cyc", fall, 2624);
    chk("hs_a_fall_x", fx, 656);
    chk("hs_a_rise_cyc", rise, 3008);
    chk("hs_a_rise_x", rx, 752);
    chk("hs_a_low_clks", lo, 384);
    chk("fs_a_line0", fsn, 0);
    chk("x_a_799", x_a, 799);
    chk("y_a_line0", y_a, 0);
    chk("tick_a_799", tick_a, 1);
    adv(1);
    chk("x_a_wrap", x_a, 0);
    chk("y_a_inc", y_a, 1);
    chk("vo_a_l1", vo_a, 1);
    chk("hs_a_l1", hs_a, 1);
    chk("vs_a_l1", vs_a, 1);

    chk("x_b_l2", x_b, 0);
    chk("y_b_l2", y_b, 2);
    lo = 0; fall = -1; rise = -1; fx = 0; rx = 0;
    for (int i = 0; i < 1599; i++) begin
      if (!hs_b) begin
        lo++;
        if (fall < 0) begin fall = cyc; fx = int'(x_b); end
      end else if (fall >= 0 && rise < 0) begin
        rise = cyc; rx = int'(x_b);
      end
      adv(1);
    end
    chk("hs_b_fall_cyc", fall, 4512);
    chk("hs_b_fall_x", fx, 656);
    chk("hs_b_rise_cyc", rise, 4704);
    chk("hs_b_rise_x", rx, 752);
    chk("hs_b_low_clks", lo, 192);
    chk("x_b_799", x_b, 799);
    chk("y_b_799", y_b, 2);
    adv(1);
    chk("x_b_l3", x_b, 0);
    chk("y_b_l3", y_b, 3);

    lo = 0; fall = -1; rise = -1; fx = 0; rx = 0; fsn = 0;
    vo_late = 0; vo_l3 = 0;
    for (int i = 0; i < 11199; i++) begin
      if (!vs_b) begin
        lo++;
        if (fall < 0) begin fall = cyc; fx = int'(y_b); end
      end else if (fall >= 0 && rise < 0) begin
        rise = cyc; rx = int'(y_b);
      end
      if (vo_b) begin
        if (cyc >= 6400) vo_late++;
        else vo_l3++;
      end
      fsn += int'(fs_b);
      adv(1);
    end
    chk("vs_b_fall_cyc", fall, 9600);
    chk("vs_b_fall_y", fx, 6);
    chk("vs_b_rise_cyc", rise, 12800);
    chk("vs_b_rise_y", rx, 8);
    chk("vs_b_low_clks", lo, 3200);
    chk("vo_b_blank_lines", vo_late, 0);
    chk("vo_b_line3", vo_l3, 1280);
    chk("fs_b_mid", fsn, 0);
    chk("x_b_last", x_b, 799);
    chk("y_b_last", y_b, 9);
    chk("fs_b_last", fs_b, 0);
    adv(1);
    chk("x_b_wrap", x_b, 0);
    chk("y_b_wrap", y_b, 0);
    chk("fs_b_pulse", fs_b, 1);
    chk("vo_b_wrap", vo_b, 1);
    chk("vs_b_wrap", vs_b, 1);
    chk("hs_b_wrap", hs_b, 1);
    adv(1);
    chk("fs_b_one_clk", fs_b, 0);

    fsn = 0; fs_first = -1;
    for (int i = 0; i < 16000; i++) begin
      if (fs_b && fs_first < 0) fs_first = cyc;
      fsn += int'(fs_b);
      adv(1);
    end
    chk("fs_b_second_cyc", fs_first, 32000);
    chk("fs_b_second_cnt", fsn, 1);

    goto(44600);
    chk("x_b_pre", x_b, 700);
    chk("y_b_pre", y_b, 7);
    chk("hs_b_pre", hs_b, 0);
    chk("vs_b_pre", vs_b, 0);
    chk("x_a_pre", x_a, 750);
    chk("y_a_pre", y_a, 13);
    chk("hs_a_pre", hs_a, 0);
    #2;
    rst_a = 1'b0;
    rst_b = 1'b0;
    #1;
    chk("arst_x_b", x_b, 0);
    chk("arst_y_b", y_b, 0);
    chk("arst_hs_b", hs_b, 1);
    chk("arst_vs_b", vs_b, 1);
    chk("arst_vo_b", vo_b, 1);
    chk("arst_fs_b", fs_b, 0);
    chk("arst_tick_b", tick_b, 0);
    chk("arst_x_a", x_a, 0);
    chk("arst_y_a", y_a, 0);
    chk("arst_hs_a", hs_a, 1);
    adv(3);
    chk("hold_x_a", x_a, 0);
    chk("hold_tick_a", tick_a, 0);

    rst_a = 1'b1;
    rst_b = 1'b1;
    cyc = 0;
    chk("re_tick_a0", tick_a, 0);
    chk("re_tick_b0", tick_b, 0);
    adv(1);
    chk("re_tick_b1", tick_b, 1);
    chk("re_tick_a1", tick_a, 0);
    adv(1);
    chk("re_x_b2", x_b, 1);
    chk("re_y_b2", y_b, 0);
    goto(3);
    chk("re_tick_a3", tick_a, 1);
    adv(1);
    chk("re_x_a4", x_a, 1);
    chk("re_y_a4", y_a, 0);
    chk("re_fs_a4", fs_a, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
